// File: rtl/control_sequencer.sv
`default_nettype none
// ==== control_sequencer : FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving a 4x8 register file (rev 1.0) ====
module control_sequencer #(
   parameter int DATA_W   = 8,
   parameter int PC_W     = 8,
   parameter int PC_RESET = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [7:0]        instr,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic [1:0]        read_reg1,
   output logic [1:0]        read_reg2,
   output logic [1:0]        write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              signal_regwrite,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic [7:0]        retired
);

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   localparam logic [1:0] c_OP_ADD  = 2'b00;
   localparam logic [1:0] c_OP_SUB  = 2'b01;
   localparam logic [1:0] c_OP_ADDI = 2'b10;

   state_t              state_q, state_d;
   logic [7:0]          ir_q, ir_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          retired_q, retired_d;

   logic [1:0]          w_op;
   logic [DATA_W-1:0]   w_imm;
   logic [PC_W-1:0]     w_off;

   assign w_op  = ir_q[7:6];
   assign w_imm = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
   // Jump offset is relative to the pc already incremented at accept.
   assign w_off = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         ir_q      <= 8'd0;
         pc_q      <= PC_W'(PC_RESET);
         wdata_q   <= '0;
         retired_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         pc_q      <= pc_d;
         wdata_q   <= wdata_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      pc_d      = pc_q;
      wdata_d   = wdata_q;
      retired_d = retired_q;
      case (state_q)
         FETCH: begin
            if (instr_valid) begin
               ir_d    = instr;
               pc_d    = pc_q + PC_W'(1);
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = EXECUTE;
         end
         EXECUTE: begin
            state_d = WRITEBACK;
            case (w_op)
               c_OP_ADD:  wdata_d = operand_a + operand_b;
               c_OP_SUB:  wdata_d = operand_a - operand_b;
               c_OP_ADDI: wdata_d = operand_a + w_imm;
               default: begin
                  pc_d      = pc_q + w_off;
                  retired_d = retired_q + 8'd1;
                  state_d   = FETCH;
               end
            endcase
         end
         WRITEBACK: begin
            retired_d = retired_q + 8'd1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign instr_ready     = (state_q == FETCH);
   assign busy            = (state_q != FETCH);
   assign signal_regwrite = (state_q == WRITEBACK);
   assign read_reg1       = ir_q[5:4];
   assign read_reg2       = ir_q[3:2];
   assign write_reg       = (w_op == c_OP_ADDI) ? ir_q[3:2] : ir_q[1:0];
   assign write_data      = wdata_q;
   assign pc              = pc_q;
   assign retired         = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ==== tb_control_sequencer : directed bench with a transaction-level reference model (rev 1.0) ====
module tb_control_sequencer;

   logic       clock;
   logic       reset;
   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [1:0] read_reg1;
   logic [1:0] read_reg2;
   logic [1:0] write_reg;
   logic [7:0] write_data;
   logic       signal_regwrite;
   logic [7:0] pc;
   logic       busy;
   logic [7:0] retired;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   control_sequencer #(.DATA_W(8), .PC_W(8), .PC_RESET(0)) dut (
      .clock           (clock),
      .reset           (reset),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_ready     (instr_ready),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .read_reg1       (read_reg1),
      .read_reg2       (read_reg2),
      .write_reg       (write_reg),
      .write_data      (write_data),
      .signal_regwrite (signal_regwrite),
      .pc              (pc),
      .busy            (busy),
      .retired         (retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an in-flight instruction and the number of edges since it was accepted.
   logic       m_busy;
   int         m_age;
   logic [7:0] m_ir;
   logic [7:0] m_pc;
   logic [7:0] m_wd;
   logic [7:0] m_ret;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_age  <= 0;
         m_ir   <= 8'd0;
         m_pc   <= 8'd0;
         m_wd   <= 8'd0;
         m_ret  <= 8'd0;
      end else if (!m_busy) begin
         if (instr_valid) begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_ir   <= instr;
            m_pc   <= 8'(int'(m_pc) + 1);
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age == 1) begin
            case (m_ir[7:6])
               2'd0: m_wd <= 8'(int'(operand_a) + int'(operand_b));
               2'd1: m_wd <= 8'(int'(operand_a) - int'(operand_b));
               2'd2: m_wd <= 8'(int'(operand_a) + int'($signed(m_ir[1:0])));
               default: begin
                  m_pc   <= 8'(int'(m_pc) + int'($signed(m_ir[5:0])));
                  m_ret  <= 8'(int'(m_ret) + 1);
                  m_busy <= 1'b0;
               end
            endcase
         end else if (m_age == 2) begin
            m_ret  <= 8'(int'(m_ret) + 1);
            m_busy <= 1'b0;
         end
      end
   end

   logic       exp_rw;
   logic [1:0] exp_wr;
   assign exp_rw = m_busy && (m_age == 2) && (m_ir[7:6] != 2'd3);
   assign exp_wr = (m_ir[7:6] == 2'd2) ? m_ir[3:2] : m_ir[1:0];

   always @(negedge clock) begin
      if (cmp_en) begin
         check("m_ready",    32'(instr_ready),     32'(!m_busy));
         check("m_busy",     32'(busy),            32'(m_busy));
         check("m_pc",       32'(pc),              32'(m_pc));
         check("m_retired",  32'(retired),         32'(m_ret));
         check("m_wdata",    32'(write_data),      32'(m_wd));
         check("m_regwrite", 32'(signal_regwrite), 32'(exp_rw));
         if (m_busy) begin
            check("m_rr1", 32'(read_reg1), 32'(m_ir[5:4]));
            check("m_rr2", 32'(read_reg2), 32'(m_ir[3:2]));
         end
         if (exp_rw) check("m_wreg", 32'(write_reg), 32'(exp_wr));
      end
   end

   // Called at a negedge; returns at the negedge of the DECODE cycle.
   task automatic send(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("ready_wait", 32'(n < 20), 32'd1);
      instr_valid = 1'b1;
      instr       = ins;
      operand_a   = a;
      operand_b   = b;
      @(negedge clock);
      instr_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      instr_valid = 1'b0;
      instr       = 8'd0;
      operand_a   = 8'd0;
      operand_b   = 8'd0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      reset  = 1'b0;
      cmp_en = 1'b1;

      repeat (5) @(negedge clock);
      check("idle_ready", 32'(instr_ready), 32'd1);
      check("idle_pc",    32'(pc),          32'd0);
      check("idle_ret",   32'(retired),     32'd0);
      check("idle_rw",    32'(signal_regwrite), 32'd0);

      send(8'h9B, 8'd5, 8'd0);
      @(negedge clock);
      @(negedge clock);
      check("addi_wd", 32'(write_data), 32'h04);
      check("addi_wr", 32'(write_reg),  32'd2);
      check("addi_rw", 32'(signal_regwrite), 32'd1);
      check("addi_pc", 32'(pc), 32'd1);
      @(negedge clock);
      check("addi_rw_off", 32'(signal_regwrite), 32'd0);
      check("addi_ret",    32'(retired), 32'd1);

      instr_valid = 1'b1; instr = 8'h1B; operand_a = 8'd3; operand_b = 8'd4;
      @(negedge clock);
      instr = 8'h5B;
      check("b2b_busy1", 32'(instr_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      check("add_wd", 32'(write_data), 32'h07);
      check("add_wr", 32'(write_reg),  32'd3);
      @(negedge clock);
      check("b2b_ready", 32'(instr_ready), 32'd1);
      @(negedge clock);
      instr_valid = 1'b0;
      check("b2b_busy2", 32'(instr_ready), 32'd0);
      check("b2b_pc",    32'(pc), 32'd3);
      @(negedge clock);
      @(negedge clock);
      check("sub_wd", 32'(write_data), 32'hFF);
      check("sub_wr", 32'(write_reg),  32'd3);
      @(negedge clock);
      check("sub_ret", 32'(retired), 32'd3);

      send(8'hC0, 8'd0, 8'd0);
      send(8'hC0, 8'd0, 8'd0);
      @(negedge clock);
      @(negedge clock);
      check("j0_pc",  32'(pc),      32'd5);
      check("j0_ret", 32'(retired), 32'd5);
      send(8'hFE, 8'd0, 8'd0);
      check("jmp_pc_acc", 32'(pc), 32'd6);
      @(negedge clock);
      check("jmp_pc_ex", 32'(pc), 32'd6);
      check("jmp_rw",    32'(signal_regwrite), 32'd0);
      @(negedge clock);
      check("jmp_pc",    32'(pc), 32'd4);
      check("jmp_ready", 32'(instr_ready), 32'd1);
      check("jmp_ret",   32'(retired), 32'd6);
      send(8'hFA, 8'd0, 8'd0);
      @(negedge clock);
      @(negedge clock);
      check("jwrap_pc", 32'(pc), 32'hFF);
      send(8'h80, 8'h40, 8'd0);
      check("pcwrap_pc", 32'(pc), 32'h00);
      @(negedge clock);
      @(negedge clock);
      check("addi0_wd", 32'(write_data), 32'h40);
      check("addi0_wr", 32'(write_reg),  32'd0);
      @(negedge clock);
      check("addi0_ret", 32'(retired), 32'd8);

      send(8'h1B, 8'd10, 8'd20);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("arst_ready", 32'(instr_ready), 32'd1);
      check("arst_busy",  32'(busy),        32'd0);
      check("arst_pc",    32'(pc),          32'd0);
      check("arst_ret",   32'(retired),     32'd0);
      check("arst_wd",    32'(write_data),  32'd0);
      check("arst_rw",    32'(signal_regwrite), 32'd0);
      check("arst_rr1",   32'(read_reg1),   32'd0);
      check("arst_wr",    32'(write_reg),   32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      send(8'h9B, 8'd5, 8'd0);
      check("pwr_pc", 32'(pc), 32'd1);
      @(negedge clock);
      @(negedge clock);
      check("pwr_wd", 32'(write_data), 32'h04);
      check("pwr_rw", 32'(signal_regwrite), 32'd1);
      @(negedge clock);
      check("pwr_ret", 32'(retired), 32'd1);

      instr_valid = 1'b1; instr = 8'hC0;
      repeat (768) @(negedge clock);
      instr_valid = 1'b0;
      check("rwrap_ret",   32'(retired), 32'd1);
      check("rwrap_pc",    32'(pc),      32'd1);
      check("rwrap_ready", 32'(instr_ready), 32'd1);
      repeat (3) @(negedge clock);
      check("rwrap_hold", 32'(retired), 32'd1);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
